// File: rtl/button_pulse_bank.sv
// Multi-channel push-button front end: synchroniser, saturating debounce,
// polarity-selectable edge pulse and optional auto-repeat per channel.
module button_pulse_bank #(
  parameter int CHANNELS        = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] btn,
  input  logic [1:0]          edge_sel,
  input  logic                repeat_en,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] repeating
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX) + 1;

  // state  | meaning
  // IDLE   | no auto-repeat activity
  // DELAY  | held after press, waiting REPEAT_DELAY for first repeat
  // REPEAT | emitting a repeat pulse every REPEAT_PERIOD cycles
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

  logic sel_rise, sel_fall, exit_cond;

  always_comb begin
    sel_rise  = (edge_sel != 2'b01);
    sel_fall  = (edge_sel == 2'b01) || (edge_sel == 2'b10);
    exit_cond = ~repeat_en || (edge_sel == 2'b01);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0]          cnt_q, cnt_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    rep_state_e             state_q, state_d;
    logic                   sync_out, rise, fall, rep_pulse;

    always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], btn[i]};
      sync_out = sync_q[SYNC_STAGES-1];
      cnt_d    = '0;
      level_d  = level_q;
      rise     = 1'b0;
      fall     = 1'b0;
      if (sync_out != level_q) begin
        if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          level_d = ~level_q;
          rise    = ~level_q;
          fall    = level_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Exit from DELAY/REPEAT uses the registered level and wins over pulses.
    always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      rep_pulse = 1'b0;
      case (state_q)
        IDLE: begin
          if (rise && repeat_en && sel_rise) begin
            state_d = DELAY;
            tmr_d   = TW'(1);
          end
        end
        DELAY: begin
          if (~level_q || exit_cond) begin
            state_d = IDLE;
            tmr_d   = '0;
          end else if (tmr_q == TW'(REPEAT_DELAY)) begin
            rep_pulse = 1'b1;
            state_d   = REPEAT;
            tmr_d     = TW'(1);
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        REPEAT: begin
          if (~level_q || exit_cond) begin
            state_d = IDLE;
            tmr_d   = '0;
          end else if (tmr_q == TW'(REPEAT_PERIOD)) begin
            rep_pulse = 1'b1;
            tmr_d     = TW'(1);
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
      pulse_d = (rise && sel_rise) || (fall && sel_fall) || rep_pulse;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        tmr_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
        state_q <= IDLE;
      end else begin
        sync_q  <= sync_d;
        cnt_q   <= cnt_d;
        tmr_q   <= tmr_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
        state_q <= state_d;
      end
    end

    assign pulse[i]     = pulse_q;
    assign level[i]     = level_q;
    assign repeating[i] = (state_q == REPEAT);
  end

endmodule

// File: tb/tb_button_pulse_bank.sv
// Directed and randomised checks of button_pulse_bank against a
// cycle-numbered behavioural model (two channels, default timing).
module tb_button_pulse_bank;
  localparam int CH    = 2;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int RDLY  = 10;
  localparam int RPER  = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH-1:0] btn = '0;
  logic [1:0]    edge_sel = 2'b00;
  logic          repeat_en = 1'b0;
  logic [CH-1:0] pulse, level, repeating;

  int checks = 0;
  int errors = 0;

  button_pulse_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut (
    .clock(clock), .reset_n(reset_n), .btn(btn), .edge_sel(edge_sel),
    .repeat_en(repeat_en), .pulse(pulse), .level(level), .repeating(repeating)
  );

  always #5 clock = ~clock;

  // Model: sync output = btn seen SYNC edges ago; level flips once a
  // disagreement has lasted DEB edges; repeats follow an absolute schedule.
  int            cyc = 0;
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_lvl, m_pulse, m_rep, m_act;
  int            run[CH];
  int            next_rep[CH];
  int            pc[CH];

  task automatic model_reset();
    hist.delete();
    m_lvl = '0; m_pulse = '0; m_rep = '0; m_act = '0;
    for (int c = 0; c < CH; c++) begin
      run[c] = 0;
      next_rep[c] = 0;
    end
  endtask

  task automatic model_step();
    logic [CH-1:0] s;
    logic old, tog, ep, rp;
    cyc++;
    if (!reset_n) begin
      model_reset();
      return;
    end
    s = (hist.size() >= SYNC) ? hist[hist.size()-SYNC] : '0;
    hist.push_back(btn);
    if (hist.size() > SYNC) void'(hist.pop_front());
    for (int c = 0; c < CH; c++) begin
      old = m_lvl[c];
      tog = 1'b0;
      if (s[c] != m_lvl[c]) begin
        run[c]++;
        if (run[c] == DEB) begin
          tog = 1'b1;
          m_lvl[c] = ~old;
          run[c] = 0;
        end
      end else begin
        run[c] = 0;
      end
      ep = tog && ((!old && edge_sel != 2'd1) || (old && (edge_sel == 2'd1 || edge_sel == 2'd2)));
      rp = 1'b0;
      if (m_act[c]) begin
        if (!old || !repeat_en || edge_sel == 2'd1) begin
          m_act[c] = 1'b0;
          m_rep[c] = 1'b0;
        end else if (cyc == next_rep[c]) begin
          rp = 1'b1;
          m_rep[c] = 1'b1;
          next_rep[c] = cyc + RPER;
        end
      end else if (tog && !old && repeat_en && edge_sel != 2'd1) begin
        m_act[c] = 1'b1;
        next_rep[c] = cyc + RDLY;
      end
      m_pulse[c] = ep | rp;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    for (int c = 0; c < CH; c++) if (pulse[c]) pc[c]++;
    chk("pulse", 32'(pulse), 32'(m_pulse));
    chk("level", 32'(level), 32'(m_lvl));
    chk("repeating", 32'(repeating), 32'(m_rep));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int p0, k;
    int offs[$];
    int exp_offs[7] = '{10, 13, 16, 19, 22, 25, 28};
    model_reset();
    pc[0] = 0; pc[1] = 0;

    // 1: reset state, then basic press latency with rising edge select
    ticks(2);
    chk("reset_outputs", 32'({pulse, level, repeating}), 32'd0);
    reset_n = 1'b1;
    btn = 2'b01;
    ticks(5);
    chk("t1_level_before_6", 32'(level[0]), 32'd0);
    tick();
    chk("t1_pulse_edge6", 32'(pulse), 32'd1);
    chk("t1_level_edge6", 32'(level[0]), 32'd1);
    tick();
    chk("t1_pulse_width", 32'(pulse), 32'd0);
    ticks(10);
    btn = 2'b00;
    ticks(12);
    chk("t1_pulse_count", 32'(pc[0]), 32'd1);
    chk("t1_ch1_silent", 32'(pc[1]), 32'd0);

    // 2: glitch rejection, then the shortest accepted excursion
    pc[0] = 0;
    btn = 2'b01; ticks(3);
    btn = 2'b00; ticks(12);
    chk("t2_glitch_no_pulse", 32'(pc[0]), 32'd0);
    btn = 2'b01; ticks(4);
    btn = 2'b00; ticks(14);
    chk("t2_min_press_pulse", 32'(pc[0]), 32'd1);

    // 3: both-edge select on channel 1
    pc[1] = 0;
    edge_sel = 2'b10;
    btn = 2'b10; ticks(20);
    btn = 2'b00; ticks(15);
    chk("t3_both_edges", 32'(pc[1]), 32'd2);

    // 4: auto-repeat while held
    edge_sel = 2'b00;
    repeat_en = 1'b1;
    btn = 2'b01;
    k = 0;
    do begin tick(); k++; end while (!pulse[0] && k < 20);
    chk("t4_press_seen", 32'(pulse[0]), 32'd1);
    p0 = cyc;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pulse[0]) offs.push_back(cyc - p0);
      if (cyc - p0 == 9)  chk("t4_not_repeating_yet", 32'(repeating[0]), 32'd0);
      if (cyc - p0 == 10) chk("t4_repeating", 32'(repeating[0]), 32'd1);
    end
    chk("t4_repeat_count", 32'(offs.size()), 32'd7);
    for (int i = 0; i < 7 && i < offs.size(); i++) chk("t4_repeat_offset", 32'(offs[i]), 32'(exp_offs[i]));
    btn = 2'b00;
    ticks(8);
    pc[0] = 0;
    ticks(10);
    chk("t4_after_release_silent", 32'(pc[0]), 32'd0);
    chk("t4_repeating_cleared", 32'(repeating[0]), 32'd0);

    // 5: simultaneous press on both channels
    repeat_en = 1'b0;
    btn = 2'b11;
    k = 0;
    do begin tick(); k++; end while (pulse == 2'b00 && k < 20);
    chk("t5_simultaneous", 32'(pulse), 32'd3);
    btn = 2'b00; ticks(12);

    // 6: reset in the middle of DELAY with button held
    repeat_en = 1'b1;
    btn = 2'b01;
    ticks(9);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("t6_reset_async", 32'({pulse, level, repeating}), 32'd0);
    ticks(2);
    reset_n = 1'b1;
    ticks(5);
    chk("t6_no_early_pulse", 32'(pulse), 32'd0);
    tick();
    chk("t6_fresh_press", 32'(pulse), 32'd1);
    ticks(20);

    // randomised traffic, every cycle compared against the model
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(5) == 0) btn[c] = ~btn[c];
      if ($urandom_range(39) == 0) edge_sel = 2'($urandom_range(3));
      if ($urandom_range(49) == 0) repeat_en = ~repeat_en;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_pulse_bank.md
# button_pulse_bank

Multi-channel successor to the single-cycle push-button pulser. Each of `CHANNELS` raw button inputs is synchronised, debounced by a saturating counter, and edge-detected with run-time selectable polarity. An optional auto-repeat mode emits periodic pulses while a button is held. The block sits between the board pushbuttons and the control FSMs, replacing per-button pulser instances.

## Interface

Parameters:
- `CHANNELS`, 5: number of independent button channels, ≥1
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥2
- `DEBOUNCE_CYCLES`, 4: cycles a synchronised level must hold before acceptance, ≥1
- `REPEAT_DELAY`, 10: cycles from press pulse to first repeat pulse, ≥2
- `REPEAT_PERIOD`, 3: cycles between subsequent repeat pulses, ≥2

Ports (one clock; reset is asynchronous and active-low):
- `clock` in 1: single system clock; all state on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `btn` in `CHANNELS`: raw, asynchronous button levels
- `edge_sel` in 2: 00 rise, 01 fall, 10 both, 11 reserved (behaves as 00)
- `repeat_en` in 1: enables auto-repeat
- `pulse` out `CHANNELS`: one-cycle event pulses
- `level` out `CHANNELS`: debounced button level
- `repeating` out `CHANNELS`: channel is in the REPEAT state

## Operation

- Per channel: a `SYNC_STAGES` flop chain, then a debounce counter of width clog2(`DEBOUNCE_CYCLES`)+1.
- Debounce: while sync output equals `level`, the counter is 0. While it differs, the counter increments each cycle. On the edge where it differs and counter == `DEBOUNCE_CYCLES`-1, `level` toggles and the counter clears.
- Edge pulse: asserted on the same edge that toggles `level`, when the transition matches `edge_sel`. Rising = 0→1; falling = 1→0; both = either.
- Auto-repeat FSM per channel, with states IDLE, DELAY and REPEAT, and one timer of width clog2(max(`REPEAT_DELAY`,`REPEAT_PERIOD`))+1:
  - IDLE→DELAY: on a rising `level` transition when `repeat_en`=1 and `edge_sel` ∈ {00,10,11}. Timer loads 1.
  - DELAY: timer increments. When timer == `REPEAT_DELAY`, emit pulse, go to REPEAT, timer loads 1.
  - REPEAT: timer increments. When timer == `REPEAT_PERIOD`, emit pulse and timer loads 1.
  - Any state→IDLE on the next edge if any of these holds: `level`=0, `repeat_en`=0, or `edge_sel`=01. This takes priority over pulse emission.
- `pulse` = edge pulse OR repeat pulse. Both are registered. There is never more than one pulse per cycle per channel.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulse in the same cycle.

## Timing

- Reset (asynchronous assert, release synchronous to `clock`): all sync flops, counters, `level`, `pulse`, `repeating` = 0; FSM = IDLE.
- Press latency: `btn` stable high before edge 1 → `level` and `pulse` high after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. With defaults this is edge 6.
- `pulse` width is exactly 1 cycle per event.
- Glitch rejection: a sync-output excursion shorter than `DEBOUNCE_CYCLES` cycles produces no `level` change and no pulse. With `DEBOUNCE_CYCLES`=1, every sync-output change is accepted.
- Repeat: if the press pulse occurs after edge P, repeat pulses occur after edges P+`REPEAT_DELAY`, then +`REPEAT_PERIOD`, and so on. `repeating` is high from the first repeat pulse onward.
- Release while in DELAY or REPEAT: no further repeat pulse once `level`=0. A fall pulse is still issued if `edge_sel` is 01 or 10.
- Reset mid-debounce or mid-repeat: all progress is discarded. If `btn` is still high after reset release, a fresh press is detected after full latency.
- Changes to `edge_sel` or `repeat_en` are sampled every cycle. They apply to the next `level` transition and to FSM exit; they are never retroactive.

## Test plan

Bench uses `CHANNELS`=2, defaults otherwise.

1. Reset, then `btn[0]`=1 held, `edge_sel`=00, `repeat_en`=0 → `level[0]`, `pulse[0]` rise after edge 6; `pulse[0]` is 1 cycle wide; no further pulses; channel 1 silent.
2. `btn[0]` high for 3 cycles, then low → no `level[0]` change and no pulse. Repeat with 4 cycles high → one pulse.
3. `edge_sel`=10, press and release `btn[1]` (held 20 cycles) → exactly two pulses, at press+6 and at release+6.
4. `repeat_en`=1, `edge_sel`=00, hold `btn[0]` for 30 cycles after the press pulse at P → pulses at P, P+10, P+13, P+16, …, P+28. `repeating` high from P+10. Release → no further pulses; `repeating` returns to 0.
5. Both channels pressed on the same edge → `pulse` = 2'b11 in a single cycle.
6. Assert `reset_n`=0 mid-DELAY with `btn` held, release after 2 cycles → all outputs 0 during reset; a new press pulse 6 cycles after release.
